// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit carry-lookahead slice walks the
// operands LSB nibble first, with valid/ready handshakes on request and result.

module carry_lookahead_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is expanded from generate/propagate terms, so no carry ripples inside the slice.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic [WIDTH-1:0] sum_sh_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             a_msb_q;
    logic             b_msb_q;

    logic [3:0]       slice_s;
    logic             slice_cout;

    carry_lookahead_adder u_slice (
        .a    (a_sh_q[3:0]),
        .b    (b_sh_q[3:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // New nibble enters at the top; after NIB steps the first nibble sits at bit 0.
    assign sum_sh_d = (sum_sh_q >> 4) | (WIDTH'(slice_s) << (WIDTH - 4));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> 4;
                    b_sh_q   <= b_sh_q >> 4;
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= slice_cout;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_sh_q;
    assign cout      = carry_q;
    assign ovf       = (a_msb_q == b_msb_q) && (sum_sh_q[WIDTH-1] != a_msb_q);
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed and random checks for cla_nibble_sequencer at WIDTH=16.

module tb_cla_nibble_sequencer;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int tests = 0;
    int fails = 0;

    cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits (bounded) for in_ready, and returns just after the accepting edge.
    task automatic start_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc);
        int w = 0;
        a = xa;
        b = xb;
        cin = xc;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        check("accept_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic wait_done(input bit rand_ready, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        out_ready = 1'b0;
    endtask

    task automatic finish_op(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        check({tag, "_sum"},  {16'd0, sum},  {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_release_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_release_ready"}, {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        bit          seen;
        logic [16:0] full;
        logic [15:0] xa, xb;
        logic        xc, eo;

        vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7]  = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[8]  = '{16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[9]  = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        a = 16'h1111;
        b = 16'h2222;
        cin = 1'b1;
        step();
        step();
        step();
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum",       {16'd0, sum},       32'd0);
        check("rst_cout",      {31'd0, cout},      32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // out_ready while idle must not create a result
        out_ready = 1'b1;
        step();
        step();
        check("idle_out_ready_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(1'b0, lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd4);
            finish_op($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // Backpressure: result holds, no accept while DONE
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(1'b0, lat);
        check("bp_latency", lat, 32'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = 16'($urandom);
            b = 16'($urandom);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum",  {16'd0, sum},  32'h5555);
            check("bp_cout", {31'd0, cout}, 32'd0);
            check("bp_ovf",  {31'd0, ovf},  32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("bp_no_reaccept", {31'd0, in_ready}, 32'd1);

        // Reset after two RUN steps aborts the operation
        start_op(16'h1234, 16'h1111, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_in_ready_in_rst", {31'd0, in_ready},  32'd0);
        check("abort_out_valid",       {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("abort_idle", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_pulse", {31'd0, seen}, 32'd0);
        start_op(16'h00FF, 16'h0001, 1'b0);
        wait_done(1'b0, lat);
        check("abort_next_latency", lat, 32'd4);
        finish_op("abort_next", 16'h0100, 1'b0, 1'b0);

        // Random regression with idle/backpressure gaps
        for (int i = 0; i < 1000; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
            xa = 16'($urandom);
            xb = 16'($urandom);
            xc = 1'($urandom);
            full = {1'b0, xa} + {1'b0, xb} + {16'd0, xc};
            eo = (xa[15] == xb[15]) && (full[15] != xa[15]);
            start_op(xa, xb, xc);
            wait_done(1'b1, lat);
            check("rand_latency", lat, 32'd4);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            check("rand_result", {14'd0, cout, ovf, sum}, {14'd0, full[16], eo, full[15:0]});
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check("rand_release", {30'd0, out_valid, in_ready}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
